// File: rtl/pipelined_mac_multiplier.sv
// Multi-lane pipelined signed fixed-point multiplier with round/shift and overflow flags.
// Define MULT_SATURATE_EN to clamp overflowing lanes; otherwise results wrap.
module pipelined_mac_multiplier #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 8,
  parameter int LANES     = 4,
  parameter int STAGES    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         round_en,
  input  logic [LANES*A_WIDTH-1:0]     a,
  input  logic [LANES*B_WIDTH-1:0]     b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out,
  output logic [LANES-1:0]             ovf
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int RW = PW + 1;
  localparam int SH = (OUT_SCALE > 0) ? OUT_SCALE - 1 : 0;
  localparam logic [RW-1:0] HALF = (OUT_SCALE > 0) ? (RW'(1) << SH) : '0;
  localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

  logic [LANES*OUT_WIDTH-1:0] out_next;
  logic [LANES-1:0]           ovf_next;

  // Full arithmetic (multiply, round, shift, clip) happens ahead of stage 1;
  // the remaining stages carry the finished result so every stage shifts uniformly.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [A_WIDTH-1:0] a_l;
    logic signed [B_WIDTH-1:0] b_l;
    logic signed [PW-1:0]      prod;
    logic signed [RW-1:0]      biased;
    logic signed [RW-1:0]      res;
    logic                      over;
    logic [OUT_WIDTH-1:0]      clip;

    assign a_l    = a[i*A_WIDTH +: A_WIDTH];
    assign b_l    = b[i*B_WIDTH +: B_WIDTH];
    assign prod   = a_l * b_l;
    assign biased = {prod[PW-1], prod} + (round_en ? HALF : '0);
    assign res    = biased >>> OUT_SCALE;
    assign over   = (res > OUT_MAX) || (res < OUT_MIN);

`ifdef MULT_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    assign clip = over ? (res[RW-1] ? SAT_MIN : SAT_MAX) : res[OUT_WIDTH-1:0];
`else
    assign clip = res[OUT_WIDTH-1:0];
`endif

    assign out_next[i*OUT_WIDTH +: OUT_WIDTH] = clip;
    assign ovf_next[i]                        = over;
  end

  logic [STAGES-1:0]          vld;
  logic [LANES*OUT_WIDTH-1:0] dat [STAGES];
  logic [LANES-1:0]           flg [STAGES];
  logic                       advance;

  // Handshake: a beat transfers on any edge where valid & ready are both 1.
  // The whole pipe stalls together, so ready upstream is just "output slot free or draining".
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[STAGES-1];
  assign out       = dat[STAGES-1];
  assign ovf       = flg[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat[s] <= '0;
        flg[s] <= '0;
      end
    end else if (advance) begin
      vld[0] <= in_valid;
      dat[0] <= out_next;
      flg[0] <= ovf_next;
      for (int s = 1; s < STAGES; s++) begin
        vld[s] <= vld[s-1];
        dat[s] <= dat[s-1];
        flg[s] <= flg[s-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mac_multiplier.sv
// Self-checking bench for pipelined_mac_multiplier at default parameters.
// Build with or without MULT_SATURATE_EN; expectations follow the same macro.
module tb_pipelined_mac_multiplier;

  localparam int LANES = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int OW = 16;
  localparam int SC = 8;
  localparam int DW = LANES*OW + LANES;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic                round_en;
  logic [LANES*AW-1:0] a;
  logic [LANES*BW-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*OW-1:0] out;
  logic [LANES-1:0]    ovf;

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  pipelined_mac_multiplier dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .round_en(round_en),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, floor-shift, range test, then clamp or wrap.
  function automatic logic [DW-1:0] model(input logic [63:0] av, input logic [63:0] bv,
                                          input logic re);
    logic [63:0] o;
    logic [3:0]  f;
    longint      p;
    longint      r;
    o = '0;
    f = '0;
    for (int i = 0; i < LANES; i++) begin
      p = longint'($signed(av[i*AW +: AW])) * longint'($signed(bv[i*BW +: BW]));
      r = (p + (re ? (longint'(1) <<< (SC-1)) : longint'(0))) >>> SC;
      f[i] = (r > 32767) || (r < -32768);
`ifdef MULT_SATURATE_EN
      if (f[i]) o[i*OW +: OW] = (r > 0) ? 16'h7FFF : 16'h8000;
      else      o[i*OW +: OW] = r[15:0];
`else
      o[i*OW +: OW] = r[15:0];
`endif
    end
    return {f, o};
  endfunction

  function automatic logic [63:0] rand_bus();
    logic [63:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0: v[i*16 +: 16] = 16'h7FFF;
        1: v[i*16 +: 16] = 16'h8000;
        2: v[i*16 +: 16] = 16'($signed($urandom_range(0, 1023)) - 512);
        default: v[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // One cycle of stimulus: inputs change just after the falling edge; accepted beats are queued.
  task automatic drive(input logic iv, input logic ordy, input logic re,
                       input logic [63:0] av, input logic [63:0] bv, input bit track);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    round_en  = re;
    a         = av;
    b         = bv;
    #1;
    if (track && iv && in_ready) exp_q.push_back(model(av, bv, re));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; round_en = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, ovf, out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b ovf=%h out=%h want all zero", out_valid, ovf, out);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 1'b0, 64'h0300, 64'h0200, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: out_valid got %0b want 0 one cycle after acceptance", out_valid);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    n_cmp++;
    if ({out_valid, ovf, out} !== {1'b1, 4'h0, 64'h0600}) begin
      n_bad++;
      $display("FAIL basic_result: got valid=%0b ovf=%h out=%h want 1/0/0600", out_valid, ovf, out);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic test_round_overflow();
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic        tr [6];
    logic [15:0] te [6];
    logic        tf [6];
    ta = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    tb = '{16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h7FFF, 16'h7FFF};
    tr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef MULT_SATURATE_EN
    te = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
`else
    te = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFF00, 16'h0080};
`endif
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, tr[k], {48'h0, ta[k]}, {48'h0, tb[k]}, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
      n_cmp++;
      if ({out_valid, ovf[0], out[15:0]} !== {1'b1, tf[k], te[k]}) begin
        n_bad++;
        $display("FAIL round_ovf[%0d]: got valid=%0b ovf=%0b out=%h want 1/%0b/%h",
                 k, out_valid, ovf[0], out[15:0], tf[k], te[k]);
      end
    end
  endtask

  task automatic test_lanes();
    logic [63:0] want;
`ifdef MULT_SATURATE_EN
    want = {16'h0001, 16'h7FFF, 16'hFA00, 16'h0600};
`else
    want = {16'h0001, 16'hFF00, 16'hFA00, 16'h0600};
`endif
    drive(1'b1, 1'b1, 1'b0, {16'h0010, 16'h7FFF, 16'hFD00, 16'h0300},
          {16'h0010, 16'h7FFF, 16'h0200, 16'h0200}, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    n_cmp++;
    if ({out_valid, ovf, out} !== {1'b1, 4'b0100, want}) begin
      n_bad++;
      $display("FAIL lanes: got valid=%0b ovf=%b out=%h want 1/0100/%h", out_valid, ovf, out, want);
    end
  endtask

  task automatic test_backpressure();
    int            sent = 0;
    int            cyc = 0;
    logic          stall;
    logic [DW-1:0] held;
    logic [DW-1:0] e;
    held = '0;
    while ((sent < 10 || exp_q.size() != 0) && cyc < 60) begin
      stall = (cyc >= 4 && cyc < 9);
      drive(sent < 10, !stall, 1'($urandom_range(0, 1)), rand_bus(), rand_bus(), 1'b1);
      if (in_valid && in_ready) sent++;
      n_cmp++;
      if (in_ready !== !stall) begin
        n_bad++;
        $display("FAIL bp_in_ready[%0d]: got %0b want %0b", cyc, in_ready, !stall);
      end
      if (stall) begin
        if (cyc == 4) held = {ovf, out};
        else begin
          n_cmp++;
          if ({out_valid, ovf, out} !== {1'b1, held}) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got %0b/%h want 1/%h", cyc, out_valid, {ovf, out}, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: got %h want no beat", {ovf, out});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, out} !== e) begin
            n_bad++;
            $display("FAIL bp_data: got %h want %h", {ovf, out}, e);
          end
        end
      end
      cyc++;
    end
    n_cmp++;
    if (sent != 10 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_timeout: got sent=%0d pending=%0d want 10/0", sent, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    for (int cyc = 0; cyc < 320; cyc++) begin
      drive(cyc < 300 && $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7 || cyc >= 300,
            1'($urandom_range(0, 1)), rand_bus(), rand_bus(), 1'b1);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra: got %h want no beat", {ovf, out});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, out} !== e) begin
            n_bad++;
            $display("FAIL b2b_data: got %h want %h", {ovf, out}, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0]   av;
    logic [63:0]   bv;
    logic [DW-1:0] e;
    drive(1'b1, 1'b1, 1'b0, rand_bus(), rand_bus(), 1'b0);
    drive(1'b1, 1'b1, 1'b1, rand_bus(), rand_bus(), 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, ovf, out} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got valid=%0b ovf=%h out=%h want all zero", out_valid, ovf, out);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_stale[%0d]: out_valid got %0b want 0", k, out_valid);
      end
    end
    av = rand_bus();
    bv = rand_bus();
    e  = model(av, bv, 1'b1);
    drive(1'b1, 1'b1, 1'b1, av, bv, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_latency_early: out_valid got %0b want 0", out_valid);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
    n_cmp++;
    if ({out_valid, ovf, out} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL rst_next_beat: got %0b/%h want 1/%h", out_valid, {ovf, out}, e);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_overflow();
    test_lanes();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
